// File: rtl/pdm_rx_decimator.sv
// PDM receiver: 2nd-order CIC decimator by 2^DECIM_LOG2 to signed PCM with a valid/ready output register.
// Optional macro PDM_RX_SYNC_EN inserts a 2-flop synchronizer on pdm_in.
module pdm_rx_decimator #(
    parameter int unsigned OUTPUT_BITS = 12,
    parameter int unsigned DECIM_LOG2  = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          pdm_in,
    output logic signed [OUTPUT_BITS-1:0] dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam int unsigned W     = 2 * DECIM_LOG2 + 1;
    localparam int unsigned CW    = DECIM_LOG2;
    localparam int unsigned SHIFT = 2 * DECIM_LOG2 - OUTPUT_BITS;
    localparam int unsigned UW    = W - SHIFT;

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_e;

    state_e                   state_q, state_d;
    logic                     warm_q, warm_d;
    logic [W-1:0]             i1_q, i1_d, i2_q, i2_d;
    logic [W-1:0]             d1_q, d1_d, d2_q, d2_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OUTPUT_BITS-1:0]   dout_q, dout_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;

    logic                     pdm_bit;
    logic [W-1:0]             i2_next, c1, c2;
    logic [UW-1:0]            u;
    logic [OUTPUT_BITS-1:0]   smp;
    logic                     dec, load;

`ifdef PDM_RX_SYNC_EN
    logic [1:0] sync_q;

    // Metastability guard for an asynchronous external bitstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], pdm_in};
    end
    assign pdm_bit = sync_q[1];
`else
    assign pdm_bit = pdm_in;
`endif

    // CIC datapath: integrators wrap modulo 2^W by design.
    always_comb begin
        i2_next = i2_q + i1_q;
        c1      = i2_next - d1_q;
        c2      = c1 - d2_q;
        dec     = &cnt_q;
        u       = c2[W-1:SHIFT];
        // Offset-binary to signed is an MSB flip; only u == 2^OUTPUT_BITS can overflow.
        if (u[UW-1]) smp = {1'b0, {(OUTPUT_BITS-1){1'b1}}};
        else         smp = {~u[OUTPUT_BITS-1], u[OUTPUT_BITS-2:0]};
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        load    = 1'b0;

        if (clr_overrun) ovr_d = 1'b0;

        if (!en) begin
            state_d = IDLE;
            warm_d  = 1'b0;
            i1_d    = '0;
            i2_d    = '0;
            d1_d    = '0;
            d2_d    = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            i1_d  = i1_q + W'(pdm_bit);
            i2_d  = i2_next;
            cnt_d = cnt_q + CW'(1);
            if (dec) begin
                d1_d = i2_next;
                d2_d = c1;
            end
            if (valid_q && dout_ready) valid_d = 1'b0;

            // Two decimations are needed before the comb delays hold real history.
            case (state_q)
                IDLE: begin
                    state_d = WARMUP;
                    warm_d  = 1'b0;
                end
                WARMUP: begin
                    if (dec) begin
                        if (warm_q) state_d = RUN;
                        else        warm_d  = 1'b1;
                    end
                end
                RUN:     load = dec;
                default: state_d = IDLE;
            endcase

            if (load) begin
                dout_d  = smp;
                valid_d = 1'b1;
                if (valid_q && !dout_ready) ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            warm_q  <= 1'b0;
            i1_q    <= '0;
            i2_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = $signed(dout_q);
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_pdm_rx_decimator.sv
// Directed bench for pdm_rx_decimator with a triangular-FIR reference model and sample scoreboard.
module tb_pdm_rx_decimator;

    localparam int R = 64;

    logic               clk = 1'b0;
    logic               rst_n, en, pdm_in, dout_ready, clr_overrun;
    logic signed [11:0] dout;
    logic               dout_valid, overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int nbits     = 0;
    int sd_acc    = 0;
    bit hist [0:1023];
    logic signed [31:0] exp_q [$];
    logic signed [31:0] d_loop;

    pdm_rx_decimator #(.OUTPUT_BITS(12), .DECIM_LOG2(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pdm_in      (pdm_in),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: CIC2 output equals a triangular FIR over the previous 2R-1 bits.
    function automatic logic signed [31:0] model(input int n);
        int acc = 0;
        for (int l = 1; l < 2 * R; l++)
            acc += ((l <= R) ? l : 2 * R - l) * int'(hist[n - l]);
        acc -= 2048;
        if (acc > 2047)  acc = 2047;
        if (acc < -2048) acc = -2048;
        return acc;
    endfunction

    task automatic run_bit(input logic b);
        logic exp_v;
        pdm_in = b;
        en     = 1'b1;
        nbits++;
        hist[nbits] = b;
        exp_v = (nbits >= 3 * R) && (nbits % R == 0);
        if (exp_v) exp_q.push_back(model(nbits));
        @(posedge clk); #1;
        check("valid_timing", dout_valid, exp_v);
        if (dout_valid) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else                   check("sample", dout, exp_q.pop_front());
        end
    endtask

    // mode 0: zeros, 1: ones, 2: alternating, 3: first-order sigma-delta of din=1000
    task automatic run_phase(input int mode, input int n);
        logic b;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       b = 1'b0;
                1:       b = 1'b1;
                2:       b = (k % 2 == 0);
                default: begin
                    sd_acc += 1000 + 2048;
                    b = (sd_acc >= 4096);
                    if (b) sd_acc -= 4096;
                end
            endcase
            run_bit(b);
        end
        check("sb_leftover", exp_q.size(), 0);
    endtask

    task automatic go_idle();
        en = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", dout_valid, 0);
        nbits  = 0;
        sd_acc = 0;
    endtask

    task automatic drive(input logic b);
        pdm_in = b;
        en     = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pdm_in = 1'b0; dout_ready = 1'b1; clr_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_phase(1, 6 * R);
        check("ones_dout", dout, 2047);
        for (int k = 0; k < 20; k++) run_bit(1'b1);
        go_idle();
        check("en_drop_dout_kept", dout, 2047);
        check("en_drop_overrun", overrun, 0);

        run_phase(0, 5 * R);
        check("zeros_dout", dout, -2048);
        go_idle();

        run_phase(2, 5 * R);
        check("alt_dout", dout, 0);
        go_idle();

        run_phase(3, 8 * R);
        d_loop = dout;
        check("loop_within_4", (d_loop >= 996 && d_loop <= 1004), 1);
        go_idle();

        // Backpressure and overrun handling.
        dout_ready = 1'b0;
        repeat (3 * R) drive(1'b1);
        check("bp_first_valid", dout_valid, 1);
        check("bp_first_dout", dout, 2047);
        check("bp_first_ovr", overrun, 0);
        repeat (R - 1) drive(1'b1);
        check("bp_hold_valid", dout_valid, 1);
        check("bp_hold_ovr", overrun, 0);
        drive(1'b1);
        check("bp_ovr_set", overrun, 1);
        check("bp_ovr_valid", dout_valid, 1);
        clr_overrun = 1'b1;
        drive(1'b1);
        clr_overrun = 1'b0;
        check("bp_ovr_clr", overrun, 0);
        check("bp_clr_valid", dout_valid, 1);
        repeat (R - 2) drive(1'b1);
        dout_ready = 1'b1;
        drive(1'b1);
        check("bp_ready_with_sample_ovr", overrun, 0);
        check("bp_ready_with_sample_valid", dout_valid, 1);
        drive(1'b1);
        check("bp_consumed", dout_valid, 0);
        dout_ready = 1'b0;
        repeat (R - 1) drive(1'b1);
        check("bp_reload_valid", dout_valid, 1);
        repeat (R - 1) drive(1'b1);
        clr_overrun = 1'b1;
        drive(1'b1);
        clr_overrun = 1'b0;
        check("bp_set_wins", overrun, 1);

        // Asynchronous reset mid-frame, then warmup must repeat.
        repeat (20) drive(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_overrun", overrun, 0);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        nbits = 0;
        run_phase(1, 4 * R);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
